// File: rtl/redmule_pkg.sv
// redmule_pkg: shared types and constants for the RedMulE tile sequencer.
//   ARRAY_WIDTH          - default full tile length in beats
//   TILE_SEQ_MAX_OUT_DEF - default number of tiles allowed in flight
//   tile_seq_state_e     - sequencer FSM states
//   tile_seq_cfg_t       - configuration latched on start. Fields are sized
//                          for the widest supported build (AW <= 64, CW <= 32)
//                          and narrowed back to AW/CW at the point of use.
package redmule_pkg;

    localparam int unsigned ARRAY_WIDTH          = 8;
    localparam int unsigned TILE_SEQ_MAX_OUT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } tile_seq_state_e;

    typedef struct packed {
        logic [63:0] base_addr;
        logic [63:0] col_stride;
        logic [63:0] row_stride;
        logic [31:0] col_iters;
        logic [31:0] reuse_iters;
        logic [31:0] row_iters;
        logic [31:0] row_leftover;
    } tile_seq_cfg_t;

endpackage

// File: rtl/redmule_tile_sequencer_if.sv
// redmule_tile_sequencer_if: tile request channel between the sequencer
// (master) and one streamer source (slave).
//   req_valid / req_ready       - request handshake
//   req_base_addr / req_tot_len - tile base address and length in beats
//   tile_done                   - streamer pulse, one per completed tile
interface redmule_tile_sequencer_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned LW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_base_addr;
    logic [LW-1:0] req_tot_len;
    logic          tile_done;

    modport master (
        output req_valid, req_base_addr, req_tot_len,
        input  req_ready, tile_done
    );

    modport slave (
        input  req_valid, req_base_addr, req_tot_len,
        output req_ready, tile_done
    );
endinterface

// File: rtl/redmule_loop_counter.sv
// redmule_loop_counter: one level of the tile loop nest.
//   clk, rst  - clock, synchronous active-high clear of count and offset
//   step      - advance this level by one iteration
//   iters     - iteration count of this level (nonzero while running)
//   stride    - offset added per non-wrapping step
//   at_max    - current count is the last iteration (iters-1)
//   offs_nxt  - offset this level will hold after the current cycle; the
//               parent uses it to register the next tile address
module redmule_loop_counter #(
    parameter int unsigned CW = 16,
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic [CW-1:0] iters,
    input  logic [AW-1:0] stride,
    output logic          at_max,
    output logic [AW-1:0] offs_nxt
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] offs_q;

    assign at_max = (cnt_q == iters - CW'(1));

    always_comb begin
        cnt_d    = cnt_q;
        offs_nxt = offs_q;
        if (step) begin
            if (at_max) begin
                cnt_d    = '0;
                offs_nxt = '0;
            end else begin
                cnt_d    = cnt_q + CW'(1);
                offs_nxt = offs_q + stride;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            offs_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            offs_q <= offs_nxt;
        end
    end
endmodule

// File: rtl/redmule_tile_sequencer.sv
// redmule_tile_sequencer: walks the columns / W-reuse / rows tile loop nest
// for one input stream and issues one request per tile to its streamer.
//   clk_i, rst_i, clear_i - clock, sync active-high reset, soft clear
//   start_i + cfg inputs  - configuration latched on start while IDLE
//   req (master)          - tile request handshake and tile_done return
//   busy_o                - FSM not in IDLE
//   done_o                - one-cycle pulse when the whole nest completed
//   err_o                 - sticky: tile_done with nothing outstanding
// Optional: REDMULE_TILE_SEQ_PERF_EN adds stall_cnt_o, the saturating count
// of cycles where a request was offered but not accepted.
module redmule_tile_sequencer
    import redmule_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned CW      = 16,
    parameter int unsigned W       = ARRAY_WIDTH,
    parameter int unsigned MAX_OUT = TILE_SEQ_MAX_OUT_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [AW-1:0]        base_addr_i,
    input  logic [AW-1:0]        col_stride_i,
    input  logic [AW-1:0]        row_stride_i,
    input  logic [CW-1:0]        col_iters_i,
    input  logic [CW-1:0]        reuse_iters_i,
    input  logic [CW-1:0]        row_iters_i,
    input  logic [$clog2(W):0]   row_leftover_i,
    redmule_tile_sequencer_if.master req,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
`ifdef REDMULE_TILE_SEQ_PERF_EN
    ,
    output logic [31:0]          stall_cnt_o
`endif
);
    localparam int unsigned LW = $clog2(W) + 1;
    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    tile_seq_state_e state_q, state_d;
    tile_seq_cfg_t   cfg_q, cfg_in;

    logic soft_rst, accept, any_zero, valid, hs, last_hs;
    logic [OW-1:0] out_q;
    logic          err_q;
    logic [AW-1:0] addr_q;

    // Level 0 = columns, 1 = reuse passes, 2 = rows.
    logic [2:0]          step, at_max;
    logic [2:0][AW-1:0]  stride, offs_nxt;
    logic [2:0][CW-1:0]  iters;

    assign soft_rst = rst_i | clear_i;
    assign accept   = (state_q == IDLE) && start_i;
    assign any_zero = (col_iters_i == '0) || (reuse_iters_i == '0) || (row_iters_i == '0);

    always_comb begin
        cfg_in              = '0;
        cfg_in.base_addr    = 64'(base_addr_i);
        cfg_in.col_stride   = 64'(col_stride_i);
        cfg_in.row_stride   = 64'(row_stride_i);
        cfg_in.col_iters    = 32'(col_iters_i);
        cfg_in.reuse_iters  = 32'(reuse_iters_i);
        cfg_in.row_iters    = 32'(row_iters_i);
        cfg_in.row_leftover = 32'(row_leftover_i);
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst)    cfg_q <= '0;
        else if (accept) cfg_q <= cfg_in;
    end

    // A reuse pass revisits the same row, so that level carries no stride.
    assign stride[0] = AW'(cfg_q.col_stride);
    assign stride[1] = '0;
    assign stride[2] = AW'(cfg_q.row_stride);
    assign iters[0]  = CW'(cfg_q.col_iters);
    assign iters[1]  = CW'(cfg_q.reuse_iters);
    assign iters[2]  = CW'(cfg_q.row_iters);

    assign valid   = (state_q == ISSUE) && (out_q < OW'(MAX_OUT));
    assign hs      = valid && req.req_ready;
    assign step[0] = hs;
    assign step[1] = step[0] && at_max[0];
    assign step[2] = step[1] && at_max[1];
    assign last_hs = step[2] && at_max[2];

    for (genvar i = 0; i < 3; i++) begin : g_lvl
        redmule_loop_counter #(.CW(CW), .AW(AW)) u_cnt (
            .clk      (clk_i),
            .rst      (soft_rst | accept),
            .step     (step[i]),
            .iters    (iters[i]),
            .stride   (stride[i]),
            .at_max   (at_max[i]),
            .offs_nxt (offs_nxt[i])
        );
    end

    // Next tile address is registered on the handshake from the counters'
    // next offsets, so it is already stable when valid is re-evaluated.
    always_ff @(posedge clk_i) begin
        if (soft_rst)    addr_q <= '0;
        else if (accept) addr_q <= base_addr_i;
        else if (hs)     addr_q <= AW'(cfg_q.base_addr) + offs_nxt[2] + offs_nxt[1] + offs_nxt[0];
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            case ({hs, req.tile_done})
                2'b10: out_q <= out_q + OW'(1);
                2'b01: begin
                    if (out_q == '0) err_q <= 1'b1;
                    else             out_q <= out_q - OW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_i) state_d = any_zero ? FIN : ISSUE;
            ISSUE: if (last_hs) state_d = DRAIN;
            DRAIN: if (out_q == '0) state_d = FIN;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req.req_valid     = valid;
    assign req.req_base_addr = addr_q;
    assign req.req_tot_len   = (state_q != ISSUE) ? '0 :
                               (at_max[2] && cfg_q.row_leftover != '0) ? LW'(cfg_q.row_leftover) :
                               LW'(W);
    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == FIN);
    assign err_o  = err_q;

`ifdef REDMULE_TILE_SEQ_PERF_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk_i) begin
        if (soft_rst || accept)                              stall_q <= '0;
        else if (valid && !req.req_ready && stall_q != '1)   stall_q <= stall_q + 32'd1;
    end
    assign stall_cnt_o = stall_q;
`endif
endmodule
